// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and helpers for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  localparam int C_MAX_REQ = 8;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Index reached by stepping 'offset' places past 'base' around a ring of n.
  function automatic int rotate_idx(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin picker; first request at or after the pointer wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic                i_advance,
  output logic [NUM_REQ-1:0]  o_grant,
  output logic [ID_WIDTH-1:0] o_grant_id,
  output logic                o_grant_any
);

  logic [ID_WIDTH-1:0] r_ptr;
  logic [ID_WIDTH-1:0] w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_id  = '0;
    o_grant_any = 1'b0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_WIDTH'(rotate_idx(int'(r_ptr), k, NUM_REQ));
      if (!o_grant_any && i_req[w_idx]) begin
        o_grant_any    = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_id     = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_advance && o_grant_any) begin
      r_ptr <= ID_WIDTH'(rotate_idx(int'(o_grant_id), 1, NUM_REQ));
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares a dual-port memory between requesters; zero-fills it
//               after reset, then grants one write and one read per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int MEM_DEPTH = 16,
  parameter int MEM_WIDTH = 8,
  parameter int ADD_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADD_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [MEM_WIDTH-1:0]           rsp_rdata,
  output logic                           mem_valid,
  output logic                           mem_wr_en,
  output logic                           mem_rd_en,
  output logic [ADD_WIDTH-1:0]           mem_wr_addr,
  output logic [ADD_WIDTH-1:0]           mem_rd_addr,
  output logic [MEM_WIDTH-1:0]           mem_wr_data,
  input  logic [MEM_WIDTH-1:0]           mem_rdata,
  output logic                           init_done
);

  localparam int ID_WIDTH = id_width(NUM_REQ);

  arb_state_e            r_state, w_state_nxt;
  logic [ADD_WIDTH-1:0]  r_init_cnt;
  logic                  r_init_done;
  logic                  r_rsp_valid;
  logic [ID_WIDTH-1:0]   r_rsp_id;

  logic                  w_run;
  logic [NUM_REQ-1:0]    w_wr_req, w_rd_req, w_wr_grant, w_rd_grant;
  logic [ID_WIDTH-1:0]   w_wr_id, w_rd_id;
  logic                  w_wr_any, w_rd_any;
  logic [ADD_WIDTH-1:0]  w_addr_arr [NUM_REQ];
  logic [MEM_WIDTH-1:0]  w_data_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi] = req_addr[gi*ADD_WIDTH +: ADD_WIDTH];
    assign w_data_arr[gi] = req_wdata[gi*MEM_WIDTH +: MEM_WIDTH];
  end

  assign w_run    = (r_state == ST_RUN);
  assign w_wr_req = req_valid &  req_we & {NUM_REQ{w_run}};
  assign w_rd_req = req_valid & ~req_we & {NUM_REQ{w_run}};

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_wr_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_wr_req),
    .i_advance  (w_run),
    .o_grant    (w_wr_grant),
    .o_grant_id (w_wr_id),
    .o_grant_any(w_wr_any)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rd_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_rd_req),
    .i_advance  (w_run),
    .o_grant    (w_rd_grant),
    .o_grant_id (w_rd_id),
    .o_grant_any(w_rd_any)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_INIT;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    mem_valid   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_addr = '0;
    mem_rd_addr = '0;
    mem_wr_data = '0;
    case (r_state)
      ST_INIT: begin
        // Reset holds the state at INIT, so the fill strobe is masked by rst.
        if (rst) begin
          mem_valid   = 1'b1;
          mem_wr_en   = 1'b1;
          mem_wr_addr = r_init_cnt;
        end
        if (r_init_cnt == ADD_WIDTH'(MEM_DEPTH - 1)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        req_ready = w_wr_grant | w_rd_grant;
        mem_wr_en = w_wr_any;
        mem_rd_en = w_rd_any;
        mem_valid = w_wr_any | w_rd_any;
        if (w_wr_any) begin
          mem_wr_addr = w_addr_arr[w_wr_id];
          mem_wr_data = w_data_arr[w_wr_id];
        end
        if (w_rd_any) mem_rd_addr = w_addr_arr[w_rd_id];
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init_cnt  <= '0;
      r_init_done <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
    end else begin
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + ADD_WIDTH'(1);
      r_init_done <= (w_state_nxt == ST_RUN);
      r_rsp_valid <= w_rd_any;
      r_rsp_id    <= w_rd_id;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (r_rsp_valid) rsp_valid[r_rsp_id] = 1'b1;
    rsp_rdata = r_rsp_valid ? mem_rdata : '0;
  end

  assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed and random checks of mem_port_arbiter against a
//               memory model and a round-robin reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int N     = 2;
  localparam int DEPTH = 16;
  localparam int W     = 8;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_wdata;
  logic [W-1:0]    rsp_rdata, mem_wr_data, mem_rdata;
  logic            mem_valid, mem_wr_en, mem_rd_en, init_done;
  logic [AW-1:0]   mem_wr_addr, mem_rd_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(N), .MEM_DEPTH(DEPTH), .MEM_WIDTH(W), .ADD_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_wr_data(mem_wr_data),
    .mem_rdata(mem_rdata), .init_done(init_done)
  );

  // Dual-port memory with registered read; contents scrambled while in reset.
  logic [W-1:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_arr[i] <= W'($urandom);
    end else begin
      if (mem_valid && mem_wr_en) mem_arr[mem_wr_addr] <= mem_wr_data;
      if (mem_valid && mem_rd_en) mem_rdata <= mem_arr[mem_rd_addr];
    end
  end

  int checks, errors;

  // Reference state
  bit           m_run;
  int           m_cnt, m_wptr, m_rptr, m_pid;
  bit           m_pv;
  logic [W-1:0] m_pd;
  logic [W-1:0] m_mem [DEPTH];

  // Last observed values, for directed checks
  logic [N-1:0] o_ready, o_rspv;
  logic [W-1:0] o_rdata;
  logic         o_done, o_wen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_wptr = 0; m_rptr = 0; m_pv = 0; m_pid = 0; m_pd = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
    req_valid[i] = v;
    req_we[i]    = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*W +: W]  = d;
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 0);
    chk({tag, "_memv"},  32'({mem_valid, mem_wr_en, mem_rd_en}), 0);
    chk({tag, "_addr"},  32'({mem_wr_addr, mem_rd_addr}), 0);
    chk({tag, "_wdata"}, 32'(mem_wr_data), 0);
    chk({tag, "_rsp"},   32'({rsp_valid, rsp_rdata}), 0);
    chk({tag, "_done"},  32'(init_done), 0);
  endtask

  // One clock: compare every output at the falling edge, then advance the model.
  task automatic tick();
    int           wwin, rwin, idx;
    logic [N-1:0] e_ready, e_rspv;
    logic         e_wen, e_ren;
    logic [AW-1:0] e_waddr, e_raddr;
    logic [W-1:0] e_wdata, e_rdata;
    @(negedge clk);
    wwin = -1; rwin = -1;
    if (m_run) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_wptr + k) % N;
        if (wwin < 0 && req_valid[idx] && req_we[idx]) wwin = idx;
        idx = (m_rptr + k) % N;
        if (rwin < 0 && req_valid[idx] && !req_we[idx]) rwin = idx;
      end
    end
    e_ready = '0;
    if (wwin >= 0) e_ready[wwin] = 1'b1;
    if (rwin >= 0) e_ready[rwin] = 1'b1;
    if (!m_run) begin
      e_wen = 1'b1; e_ren = 1'b0; e_waddr = AW'(m_cnt); e_wdata = '0; e_raddr = '0;
    end else begin
      e_wen   = (wwin >= 0);
      e_ren   = (rwin >= 0);
      e_waddr = e_wen ? req_addr[wwin*AW +: AW] : '0;
      e_wdata = e_wen ? req_wdata[wwin*W +: W] : '0;
      e_raddr = e_ren ? req_addr[rwin*AW +: AW] : '0;
    end
    e_rspv = '0;
    if (m_pv) e_rspv[m_pid] = 1'b1;
    e_rdata = m_pv ? m_pd : '0;

    chk("ready",     32'(req_ready),   32'(e_ready));
    chk("mem_valid", 32'(mem_valid),   32'(e_wen | e_ren));
    chk("wr_en",     32'(mem_wr_en),   32'(e_wen));
    chk("rd_en",     32'(mem_rd_en),   32'(e_ren));
    chk("wr_addr",   32'(mem_wr_addr), 32'(e_waddr));
    chk("wr_data",   32'(mem_wr_data), 32'(e_wdata));
    chk("rd_addr",   32'(mem_rd_addr), 32'(e_raddr));
    chk("rsp_valid", 32'(rsp_valid),   32'(e_rspv));
    chk("rsp_rdata", 32'(rsp_rdata),   32'(e_rdata));
    chk("init_done", 32'(init_done),   32'(m_run));
    o_ready = req_ready; o_rspv = rsp_valid; o_rdata = rsp_rdata;
    o_done = init_done;  o_wen = mem_wr_en;

    @(posedge clk);
    if (!m_run) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1;
      m_pv = 0;
    end else begin
      m_pv = (rwin >= 0);
      if (rwin >= 0) begin
        m_pid  = rwin;
        m_pd   = m_mem[e_raddr];
        m_rptr = (rwin + 1) % N;
      end
      if (wwin >= 0) begin
        m_mem[e_waddr] = e_wdata;
        m_wptr = (wwin + 1) % N;
      end
    end
    #1;
  endtask

  task automatic run_init(input string tag);
    int wen_cycles;
    wen_cycles = 0;
    for (int c = 0; c < DEPTH; c++) begin
      tick();
      if (o_wen) wen_cycles++;
    end
    chk({tag, "_wen_cycles"}, 32'(wen_cycles), DEPTH);
    tick();
    chk({tag, "_done_rise"}, 32'(o_done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b1;
    run_init("init0");

    // Read of the last location after the zero-fill
    set_req(0, 1, 0, 4'd15, 8'h00); tick(); chk("t1_ready", 32'(o_ready), 2'b01);
    idle(); tick();
    chk("t1_rspv", 32'(o_rspv), 2'b01); chk("t1_rdata", 32'(o_rdata), 8'h00);

    // Competing writes serialise in round-robin order
    set_req(0, 1, 1, 4'd3, 8'hA5); set_req(1, 1, 1, 4'd4, 8'h5A);
    tick(); chk("t2_c1", 32'(o_ready), 2'b01);
    set_req(0, 0, 0, 4'd0, 8'h00);
    tick(); chk("t2_c2", 32'(o_ready), 2'b10);
    idle();
    set_req(0, 1, 0, 4'd3, 8'h00); tick(); idle(); tick();
    chk("t2_rd3", 32'(o_rdata), 8'hA5);
    set_req(1, 1, 0, 4'd4, 8'h00); tick(); idle(); tick();
    chk("t2_rd4", 32'(o_rdata), 8'h5A);

    // Concurrent read and write on different ports
    set_req(0, 1, 0, 4'd3, 8'h00); set_req(1, 1, 1, 4'd7, 8'h3C);
    tick(); chk("t3_ready", 32'(o_ready), 2'b11);
    idle(); tick();
    chk("t3_rspv", 32'(o_rspv), 2'b01); chk("t3_rdata", 32'(o_rdata), 8'hA5);
    set_req(1, 1, 0, 4'd7, 8'h00); tick(); idle(); tick();
    chk("t3_rd7", 32'(o_rdata), 8'h3C);

    // Same-address write and read: read sees the old value
    set_req(0, 1, 1, 4'd3, 8'h77); set_req(1, 1, 0, 4'd3, 8'h00);
    tick(); chk("t4_ready", 32'(o_ready), 2'b11);
    idle(); tick();
    chk("t4_rspv", 32'(o_rspv), 2'b10); chk("t4_old", 32'(o_rdata), 8'hA5);
    set_req(1, 1, 0, 4'd3, 8'h00); tick(); idle(); tick();
    chk("t4_new", 32'(o_rdata), 8'h77);

    // Continuous reads from both requesters alternate
    set_req(0, 1, 0, 4'd3, 8'h00); set_req(1, 1, 0, 4'd4, 8'h00);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t5_grant", 32'(o_ready), (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("t5_rsp", 32'(o_rspv), (k % 2 == 1) ? 2'b01 : 2'b10);
    end
    idle(); tick();
    chk("t5_last_rsp", 32'(o_rspv), 2'b10);

    // Randomised traffic, with addresses biased toward collisions
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        set_req(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 3)) : AW'($urandom),
                W'($urandom));
      end
      tick();
    end
    idle(); tick();

    // Reset in the cycle after a read grant drops the response
    set_req(0, 1, 0, 4'd5, 8'h00); tick(); chk("t6_grant", 32'(o_ready), 2'b01);
    idle();
    rst = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst = 1'b1;
    run_init("init1");
    set_req(1, 1, 0, 4'd5, 8'h00); tick(); idle(); tick();
    chk("t6_zero", 32'(o_rdata), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Round-robin scheduler that shares the dual-port memory between NUM_REQ requesters. Each cycle it grants at most one write (to the write port) and at most one read (to the read port), drives the memory's valid/wr_en/rd_en/address/data inputs, and routes registered read data back to the issuing requester. After every reset it runs an INIT sequence that writes zero to every memory location before accepting traffic.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MEM_DEPTH, 16, memory entries; must be <= 2**ADD_WIDTH
MEM_WIDTH, 8, data width
ADD_WIDTH, 4, address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_we  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*ADD_WIDTH  packed; requester i at slice [i*ADD_WIDTH +: ADD_WIDTH]
req_wdata  in  NUM_REQ*MEM_WIDTH  packed write data
req_ready  out  NUM_REQ  grant; transfer when req_valid & req_ready
rsp_valid  out  NUM_REQ  one-cycle read-data strobe to requester i
rsp_rdata  out  MEM_WIDTH  read data, shared bus, qualified by rsp_valid
mem_valid  out  1  to memory valid
mem_wr_en  out  1  to memory wr_en
mem_rd_en  out  1  to memory rd_en
mem_wr_addr  out  ADD_WIDTH  to memory wr_addr
mem_rd_addr  out  ADD_WIDTH  to memory rd_addr
mem_wr_data  out  MEM_WIDTH  to memory wr_data
mem_rdata  in  MEM_WIDTH  from memory rdata (registered in memory, 1-cycle latency)
init_done  out  1  high once INIT completes

Behaviour:
- Reset (rst=0, async): state=INIT, init counter=0, wr_ptr=rd_ptr=0, rsp pipeline cleared. init_done=0, rsp_valid=0. req_ready, mem_valid, mem_wr_en, mem_rd_en=0. mem addresses and wr_data=0. Any in-flight read response is dropped.
- INIT: mem_valid=1, mem_wr_en=1, mem_rd_en=0, mem_wr_addr=counter, mem_wr_data=0, req_ready=0. Counter increments each cycle. On counter==MEM_DEPTH-1 -> RUN next cycle. Duration is exactly MEM_DEPTH cycles after reset release.
- RUN: init_done=1 (registered, rises on the first RUN cycle). Grant logic is combinational from req_valid/req_we/pointers:
  - Write arbiter: candidates are req_valid[i] & req_we[i]. Winner is the first candidate at or after wr_ptr, modulo NUM_REQ.
  - Read arbiter: candidates are req_valid[i] & ~req_we[i]. Same rule using rd_ptr.
  - req_ready[i]=1 only for winners. req_ready may depend on req_valid; requesters must not depend on ready before asserting valid.
  - mem_wr_en = write granted; mem_rd_en = read granted; mem_valid = mem_wr_en | mem_rd_en.
  - Mem address/data are muxed from the winner. With no grant, hold 0.
  - Pointer update at the clock edge: on grant to i, ptr <= (i+1) mod NUM_REQ. With no grant, ptr holds. Write and read pointers are independent.
- Read response: on a read grant to i in cycle N, register the id and a valid bit. In cycle N+1, rsp_valid[i]=1 for one cycle and rsp_rdata=mem_rdata (pass-through). rsp_rdata is 0 when no rsp_valid. There is no response backpressure. Back-to-back reads give one response per cycle.
- Same-address write and read in the same cycle (any requesters): the read returns the pre-write data.
- A requester holding req_valid with unchanged payload is served within NUM_REQ cycles (round-robin bound).
- Reset asserted mid-RUN: all outputs go to reset values immediately, then INIT reruns in full.

Decomposition:
- Package mem_arb_pkg: state enum arb_state_e {ST_INIT, ST_RUN}; localparam ID_WIDTH = $clog2(NUM_REQ) (minimum 1); helper function for rotate-priority index.
- Sub-module rr_arbiter (NUM_REQ-bit request in, one-hot grant out, internal pointer, advance input). Instantiated twice: write path and read path.

Test Plan:
- Reset release with no requests -> mem_wr_en=1 for 16 cycles with addr 0..15 and data 0x00; init_done rises on cycle 17; a subsequent read of addr 15 returns rsp_rdata=0x00.
- Req0 write addr3=0xA5 and req1 write addr4=0x5A asserted together after INIT -> req_ready=2'b01 in cycle 1 and 2'b10 in cycle 2; subsequent reads return 0xA5 and 0x5A.
- Req0 read addr3 and req1 write addr7=0x3C in the same cycle -> both granted (req_ready=2'b11); rsp_valid=2'b01 next cycle with 0xA5; addr7 later reads 0x3C.
- Req0 write addr3=0x77 and req1 read addr3 in the same cycle -> rsp_valid[1] next cycle with 0xA5 (old data); the next read of addr3 returns 0x77.
- Both requesters hold continuous reads for 6 cycles -> grants alternate 0,1,0,1,0,1; each rsp_valid[i] pulses exactly one cycle after its grant.
- Reset pulsed in the cycle after a read grant -> no rsp_valid is produced; init_done=0; INIT reruns for 16 cycles.
